// File: rtl/priority_encoder_pkg.sv
// Shared definitions for the priority_encoder block.
//
// Contents:
//   DefaultWidth - default request-vector width (8)
//   MaxWidth     - widest request vector the block supports (64)
//   out_w()      - width of the encoded index for a given request width
//   pe_index()   - highest-set-bit index of a vector, used by the bench model
package priority_encoder_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MaxWidth     = 64;

  // Index width for a request vector of the given width. Never less than 1 bit,
  // so a degenerate width still yields a legal vector.
  function automatic int unsigned out_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Index of the highest set bit of vec, or 0 when no bit is set. An X/Z bit
  // fails the if-test and is therefore never counted as a request.
  function automatic int unsigned pe_index(input logic [MaxWidth-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (vec[i] == 1'b1) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_comb.sv
// Combinational core of the priority encoder.
//
// Reduces a request vector to the index of its highest set bit and flags
// whether any bit was set. No state.
//
// Parameters:
//   WIDTH - number of request bits
//   OUT_W - index width (derived by the parent)
// Ports:
//   req [WIDTH-1:0] in  - request vector
//   idx [OUT_W-1:0] out - index of highest set bit, 0 when none set
//   any             out - 1 when at least one request bit is set
module priority_encoder_comb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // Scan upward so a later (higher) hit overwrites an earlier one; the last
  // assignment therefore holds the highest set index. Defaults give idx=0 for
  // an empty vector rather than any stale value.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid flag.
//
// Reports the index of the highest set bit of the request vector one clock
// after it is sampled. Outputs come straight from flops; there is no
// combinational path from in to out.
//
// Optional feature (macro PRIORITY_ENCODER_ONEHOT_EN):
//   adds a registered one-hot copy of the winning index, sharing the reset,
//   enable and timing of out.
//
// Parameters:
//   WIDTH - request bits, power of two in 2..64
//   OUT_W - index width, derived from WIDTH
// Ports:
//   clk                 in  - clock, rising edge
//   rst                 in  - synchronous reset, active high, beats en
//   en                  in  - capture enable; outputs hold when low
//   in     [WIDTH-1:0]  in  - request vector
//   out    [OUT_W-1:0]  out - registered index of highest set bit
//   onehot [WIDTH-1:0]  out - registered one-hot of out (macro only)
//   valid               out - registered, 1 when captured vector was non-zero
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter  int unsigned WIDTH = DefaultWidth,
  localparam int unsigned OUT_W = out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  output logic [WIDTH-1:0] onehot,
`endif
  output logic             valid
);

  logic [OUT_W-1:0] idx_d;
  logic             any_d;
  logic [OUT_W-1:0] out_q;
  logic             valid_q;

  priority_encoder_comb #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_comb (
    .req (in),
    .idx (idx_d),
    .any (any_d)
  );

  // idx_d is already 0 for an empty vector, so out is forced to 0 rather than
  // holding the previous winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= idx_d;
      valid_q <= any_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] onehot_d;
  logic [WIDTH-1:0] onehot_q;

  always_comb begin
    onehot_d = '0;
    if (any_d) begin
      onehot_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_q <= '0;
    end else if (en) begin
      onehot_q <= onehot_d;
    end
  end

  assign onehot = onehot_q;
`else
  // One-hot output not built; out/valid behaviour is unchanged.
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder (WIDTH=8).
// Each step drives inputs, pushes the expected registered result onto a
// scoreboard queue, then pops and compares it one edge later.
module tb_priority_encoder;
  import priority_encoder_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  in;
  logic [OW-1:0] out;
  logic          valid;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [W-1:0]  onehot;
`endif

  typedef struct {
    logic [OW-1:0] out;
    logic          valid;
    logic [W-1:0]  onehot;
  } exp_t;

  exp_t          exp_q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [OW-1:0] m_out;
  logic          m_valid;

  always #5 clk = ~clk;

  priority_encoder #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (in),
    .out    (out),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    .onehot (onehot),
`endif
    .valid  (valid)
  );

  task automatic check(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    n_assert++;
    assert (out === e.out) else begin
      n_fail++;
      $error("FAIL %s out: got %0d expected %0d", tag, out, e.out);
    end
    n_assert++;
    assert (valid === e.valid) else begin
      n_fail++;
      $error("FAIL %s valid: got %0b expected %0b", tag, valid, e.valid);
    end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    n_assert++;
    assert (onehot === e.onehot) else begin
      n_fail++;
      $error("FAIL %s onehot: got %b expected %b", tag, onehot, e.onehot);
    end
`endif
  endtask

  // want >= 0 gives the expected index as a literal; want < 0 uses the model.
  task automatic cycle(input logic r, input logic e, input logic [W-1:0] v,
                       input int want, input string tag);
    exp_t x;
    rst = r;
    en  = e;
    in  = v;
    if (r) begin
      m_out   = '0;
      m_valid = 1'b0;
    end else if (e) begin
      m_valid = (v != '0);
      if (want >= 0) m_out = OW'(want);
      else           m_out = m_valid ? OW'(pe_index(64'(v))) : '0;
    end
    x.out    = m_out;
    x.valid  = m_valid;
    x.onehot = m_valid ? (W'(1) << m_out) : '0;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    in  = 8'hFF;

    // Reset held two edges with all requests active.
    cycle(1'b1, 1'b1, 8'hFF, 0, "reset0");
    cycle(1'b1, 1'b1, 8'hFF, 0, "reset1");
    cycle(1'b0, 1'b1, 8'hFF, 7, "post_reset");

    // Directed sequence.
    cycle(1'b0, 1'b1, 8'b0000_0000, 0, "dir_zero");
    cycle(1'b0, 1'b1, 8'b0011_1100, 5, "dir_3c");
    cycle(1'b0, 1'b1, 8'b0100_0000, 6, "dir_40");
    cycle(1'b0, 1'b1, 8'b1010_0100, 7, "dir_a4");
    cycle(1'b0, 1'b1, 8'b0000_0010, 1, "dir_02");
    cycle(1'b0, 1'b1, 8'b0000_1000, 3, "dir_08");

    // One-hot sweep; bit 0 alone must give valid=1, unlike all-zero.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, W'(1) << i, i, $sformatf("sweep%0d", i));
    end
    cycle(1'b0, 1'b1, 8'h00, 0, "zero_again");
    cycle(1'b0, 1'b1, 8'h01, 0, "bit0_only");

    // Hold with en low.
    cycle(1'b0, 1'b1, 8'b1000_0000, 7, "hold_load");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'b0000_0100, -1, $sformatf("hold%0d", i));
    end
    cycle(1'b0, 1'b1, 8'b0000_0100, 2, "reenable");

    // Reset mid-stream, then stays cleared while en is low.
    cycle(1'b0, 1'b1, 8'b0010_0000, 5, "mid_load");
    cycle(1'b1, 1'b1, 8'hF0, 0, "mid_reset");
    cycle(1'b0, 1'b1, 8'hF0, 7, "mid_after");
    cycle(1'b1, 1'b1, 8'hF0, 0, "mid_reset2");
    cycle(1'b0, 1'b0, 8'hF0, -1, "mid_noen");
    cycle(1'b0, 1'b1, 8'h0C, 3, "mid_cap");

`ifdef PRIORITY_ENCODER_ONEHOT_EN
    cycle(1'b0, 1'b1, 8'b0101_0000, 6, "oh_50");
    cycle(1'b0, 1'b1, 8'h00, 0, "oh_zero");
`endif

    // Random traffic against the model, with occasional reset and stalls.
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
            W'($urandom_range(0, 255)), -1, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
